// File: rtl/stopwatch_ctrl.sv
// Stopwatch front end: key synchronise/debounce, start/pause/lap/clear FSM,
// and the centisecond tick prescaler feeding the counter/display block.
module stopwatch_ctrl #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TICK_HZ     = 100,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       key_start_n,
  input  logic       key_clear_n,
  input  logic       key_lap_n,
  output logic       tick,
  output logic       run,
  output logic       hold,
  output logic       clear,
  output logic [1:0] state
);

  localparam int DIV       = CLK_HZ / TICK_HZ;
  localparam int DB_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int PRE_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DB_W      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);

  localparam int K_CLEAR = 0;
  localparam int K_START = 1;
  localparam int K_LAP   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  state_t           state_reg;
  logic             run_reg;
  logic             hold_reg;
  logic             clear_reg;
  logic             tick_reg;
  logic [PRE_W-1:0] pre_cnt_reg;

  logic [2:0] key_raw_n;
  logic [2:0] press;

  assign key_raw_n = {key_lap_n, key_start_n, key_clear_n};

  // Per key: two-flop synchroniser, then a counter that must see DB_CYCLES
  // consecutive disagreeing cycles before the stable level is allowed to flip.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_key
      logic            sync1_reg;
      logic            sync2_reg;
      logic            stable_reg;
      logic            press_reg;
      logic [DB_W-1:0] db_cnt_reg;

      always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
          sync1_reg  <= 1'b1;
          sync2_reg  <= 1'b1;
          stable_reg <= 1'b1;
          press_reg  <= 1'b0;
          db_cnt_reg <= '0;
        end else begin
          sync1_reg <= key_raw_n[gi];
          sync2_reg <= sync1_reg;
          press_reg <= 1'b0;
          if (sync2_reg != stable_reg) begin
            if (db_cnt_reg == DB_LAST) begin
              stable_reg <= sync2_reg;
              db_cnt_reg <= '0;
              press_reg  <= ~sync2_reg;
            end else begin
              db_cnt_reg <= db_cnt_reg + DB_W'(1);
            end
          end else begin
            db_cnt_reg <= '0;
          end
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  // Each state tests only the events it accepts, in clear > start > lap order,
  // so an invalid higher-priority event never masks a valid lower one.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      run_reg   <= 1'b0;
      hold_reg  <= 1'b0;
      clear_reg <= 1'b0;
    end else begin
      clear_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (press[K_CLEAR]) begin
            clear_reg <= 1'b1;
          end else if (press[K_START]) begin
            state_reg <= RUN;
            run_reg   <= 1'b1;
            hold_reg  <= 1'b0;
          end
        end
        RUN: begin
          if (press[K_START]) begin
            state_reg <= PAUSE;
            run_reg   <= 1'b0;
            hold_reg  <= 1'b0;
          end else if (press[K_LAP]) begin
            state_reg <= LAP;
            run_reg   <= 1'b1;
            hold_reg  <= 1'b1;
          end
        end
        PAUSE: begin
          if (press[K_CLEAR]) begin
            state_reg <= IDLE;
            run_reg   <= 1'b0;
            hold_reg  <= 1'b0;
            clear_reg <= 1'b1;
          end else if (press[K_START]) begin
            state_reg <= RUN;
            run_reg   <= 1'b1;
            hold_reg  <= 1'b0;
          end
        end
        LAP: begin
          if (press[K_START]) begin
            state_reg <= PAUSE;
            run_reg   <= 1'b0;
            hold_reg  <= 1'b0;
          end else if (press[K_LAP]) begin
            state_reg <= RUN;
            run_reg   <= 1'b1;
            hold_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          run_reg   <= 1'b0;
          hold_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Prescaler keeps its phase through PAUSE; only IDLE zeroes it.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_reg <= '0;
      tick_reg    <= 1'b0;
    end else begin
      tick_reg <= 1'b0;
      if (state_reg == IDLE) begin
        pre_cnt_reg <= '0;
      end else if (run_reg) begin
        if (pre_cnt_reg == PRE_LAST) begin
          pre_cnt_reg <= '0;
          tick_reg    <= 1'b1;
        end else begin
          pre_cnt_reg <= pre_cnt_reg + PRE_W'(1);
        end
      end
    end
  end

  assign tick  = tick_reg;
  assign run   = run_reg;
  assign hold  = hold_reg;
  assign clear = clear_reg;
  assign state = state_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed plus randomised key stimulus for stopwatch_ctrl, checked every cycle
// against a window-based debounce model, an event table and a run-time tick count.
module tb_stopwatch_ctrl;

  localparam int CLK_HZ      = 1000;
  localparam int TICK_HZ     = 100;
  localparam int DEBOUNCE_MS = 4;
  localparam int DIV         = 10;
  localparam int DB          = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       key_start_n;
  logic       key_clear_n;
  logic       key_lap_n;
  logic       tick;
  logic       run;
  logic       hold;
  logic       clear;
  logic [1:0] state;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .CLK_HZ      (CLK_HZ),
    .TICK_HZ     (TICK_HZ),
    .DEBOUNCE_MS (DEBOUNCE_MS)
  ) dut (
    .CLOCK_50    (clk),
    .reset_n     (reset_n),
    .key_start_n (key_start_n),
    .key_clear_n (key_clear_n),
    .key_lap_n   (key_lap_n),
    .tick        (tick),
    .run         (run),
    .hold        (hold),
    .clear       (clear),
    .state       (state)
  );

  int checks = 0;
  int errors = 0;
  int ticks_seen = 0;
  int clears_seen = 0;

  // Reference model: key index 0=clear, 1=start, 2=lap (also priority order)
  int m_state;
  int m_acc;
  bit m_tick;
  bit m_clear;
  bit m_stable [3];
  bit m_press [3];
  bit samp [3][DB+2];

  function automatic int trans(int s, int e);
    case (s)
      0:       trans = (e == 0) ? 0 : (e == 1) ? 1 : -1;
      1:       trans = (e == 1) ? 2 : (e == 2) ? 3 : -1;
      2:       trans = (e == 0) ? 0 : (e == 1) ? 1 : -1;
      default: trans = (e == 1) ? 2 : (e == 2) ? 1 : -1;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_acc   = 0;
    m_tick  = 1'b0;
    m_clear = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_stable[k] = 1'b1;
      m_press[k]  = 1'b0;
      for (int j = 0; j < DB + 2; j++) samp[k][j] = 1'b1;
    end
  endtask

  task automatic model_edge(input logic [2:0] raw);
    int old_state;
    bit old_run;
    bit done;
    bit diff;
    bit newp [3];
    old_state = m_state;
    old_run   = (m_state == 1) || (m_state == 3);
    m_clear   = 1'b0;
    done      = 1'b0;
    for (int e = 0; e < 3; e++) begin
      if (!done && m_press[e] && trans(old_state, e) >= 0) begin
        m_state = trans(old_state, e);
        m_clear = (e == 0);
        done    = 1'b1;
      end
    end
    // Tick on every DIV-th cycle of accumulated run time since leaving IDLE
    m_tick = 1'b0;
    if (old_state == 0) begin
      m_acc = 0;
    end else if (old_run) begin
      m_acc++;
      m_tick = ((m_acc % DIV) == 0);
    end
    // Level flips once the last DB synchronised samples (raw delayed two edges) all differ
    for (int k = 0; k < 3; k++) begin
      for (int j = DB + 1; j > 0; j--) samp[k][j] = samp[k][j-1];
      samp[k][0] = raw[k];
      diff = 1'b1;
      for (int j = 0; j < DB; j++) if (samp[k][2+j] == m_stable[k]) diff = 1'b0;
      newp[k] = 1'b0;
      if (diff) begin
        m_stable[k] = !m_stable[k];
        newp[k]     = !m_stable[k];
      end
    end
    m_press = newp;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s failed", tag);
    end
  endtask

  task automatic step();
    logic [2:0] raw;
    raw = {key_lap_n, key_start_n, key_clear_n};
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_edge(raw);
    #1;
    if (tick === 1'b1) ticks_seen++;
    if (clear === 1'b1) clears_seen++;
    check("tick", tick, m_tick);
    check("run", run, (m_state == 1) || (m_state == 3));
    check("hold", hold, m_state == 3);
    check("clear", clear, m_clear);
    check("state", state, m_state);
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0:       key_clear_n = v;
      1:       key_start_n = v;
      default: key_lap_n   = v;
    endcase
  endtask

  task automatic press(input int k, input int low);
    set_key(k, 1'b0);
    steps(low);
    set_key(k, 1'b1);
  endtask

  int n;
  int t0;
  int c0;
  int rise;
  int rem [3];
  bit lvl [3];

  initial begin
    reset_n = 1'b0;
    key_start_n = 1'b1;
    key_clear_n = 1'b1;
    key_lap_n   = 1'b1;
    model_reset();
    steps(3);
    reset_n = 1'b1;
    check("rst_state", state, 2'b00);
    check("rst_run", run, 1'b0);
    check("rst_tick", tick, 1'b0);
    t0 = ticks_seen;
    steps(100);
    check("idle_ticks", ticks_seen - t0, 0);

    // Start held low 10 cycles: run rises on the 7th edge after the fall
    rise = 0;
    set_key(1, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step();
      if (run === 1'b1 && rise == 0) rise = i;
    end
    set_key(1, 1'b1);
    check("start_rise_edge", rise, 7);
    n = 10 - rise;
    while (tick !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("first_tick_delay", n, DIV);
    t0 = ticks_seen;
    steps(30);
    check("tick_period", ticks_seen - t0, 3);

    // Bounce shorter than the window, then a real press
    press(1, 3);
    steps(1);
    press(1, 3);
    steps(12);
    check("bounce_no_event", state, 2'b01);
    press(1, 8);
    steps(10);
    check("bounce_one_press", state, 2'b10);
    press(1, 7);
    steps(10);

    // Lap freezes display, counting continues
    press(2, 7);
    steps(3);
    check("lap_hold", hold, 1'b1);
    t0 = ticks_seen;
    steps(20);
    check("lap_ticks", ticks_seen - t0, 2);
    press(2, 7);
    steps(10);
    check("lap_release_hold", hold, 1'b0);
    check("lap_release_state", state, 2'b01);

    press(1, 7);
    steps(10);
    press(0, 7);
    steps(10);
    check("to_idle", state, 2'b00);

    // Phase retention: 14 run cycles, pause, resume -> first tick after 6
    press(1, 7);
    check("phase_run", run, 1'b1);
    steps(7);
    press(1, 7);
    check("phase_pause", state, 2'b10);
    steps(50);
    press(1, 7);
    check("phase_resume", run, 1'b1);
    n = 0;
    while (tick !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    check("resume_first_tick", n, 6);
    steps(5);
    press(1, 7);
    steps(8);
    c0 = clears_seen;
    press(0, 7);
    check("clear_pulse", clear, 1'b1);
    check("clear_state", state, 2'b00);
    step();
    check("clear_one_cycle", clear, 1'b0);
    steps(8);
    check("clear_count", clears_seen - c0, 1);

    // Clear and start together in PAUSE: clear wins
    press(1, 7);
    steps(8);
    press(1, 7);
    steps(8);
    check("simul_in_pause", state, 2'b10);
    c0 = clears_seen;
    key_clear_n = 1'b0;
    key_start_n = 1'b0;
    steps(7);
    key_clear_n = 1'b1;
    key_start_n = 1'b1;
    steps(10);
    check("simul_state", state, 2'b00);
    check("simul_clears", clears_seen - c0, 1);

    // Asynchronous reset while running; start held through release
    press(1, 7);
    steps(15);
    c0 = clears_seen;
    reset_n = 1'b0;
    #1;
    check("async_rst_run", run, 1'b0);
    check("async_rst_state", state, 2'b00);
    check("async_rst_clear", clear, 1'b0);
    model_reset();
    key_start_n = 1'b0;
    steps(3);
    reset_n = 1'b1;
    steps(8);
    key_start_n = 1'b1;
    steps(10);
    check("held_through_reset", state, 2'b01);
    check("reset_no_clear", clears_seen - c0, 0);

    // Randomised key activity, model checked every cycle
    for (int k = 0; k < 3; k++) begin
      lvl[k] = 1'b1;
      rem[k] = $urandom_range(5, 40);
    end
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (rem[k] == 0) begin
          lvl[k] = !lvl[k];
          rem[k] = lvl[k] ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 10));
        end
        rem[k]--;
        set_key(k, lvl[k]);
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
